// File: rtl/decryption_seq_pkg.sv
// decryption_seq_pkg
// Shared constants, FSM state encoding and bit-level helper functions for
// the Feistel decryption datapath. The same word-swap helper is used by the
// encryption core on its output and by the decryption core on its input so
// both sides agree on half-block ordering.
//
// Bit numbering: vectors are declared [N-1:0], so "bit 0" in big-endian
// notation (Cipher[0:63]) is the upper half here (Cipher[127:64]).

package decryption_seq_pkg;

    localparam int ROUNDS = 32;
    localparam int KEY_W  = 64;
    localparam int BLK_W  = 128;
    localparam int RK_W   = 32;
    localparam int RIDX_W = 6;
    localparam int ADDR_W = $clog2(ROUNDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYGEN = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } dec_state_t;

    // Exchange the two 64-bit halves of a block.
    function automatic logic [BLK_W-1:0] word_swap(input logic [BLK_W-1:0] blk);
        return {blk[BLK_W/2-1:0], blk[BLK_W-1:BLK_W/2]};
    endfunction

    // Round function: rotate/AND/XOR mix of one half, keyed by a 32-bit
    // round key spread over 64 bits as {rk, ~rk}.
    function automatic logic [BLK_W/2-1:0] round_f(input logic [BLK_W/2-1:0] x,
                                                   input logic [RK_W-1:0]    rk);
        logic [BLK_W/2-1:0] rot1;
        logic [BLK_W/2-1:0] rot2;
        logic [BLK_W/2-1:0] rot8;
        rot1 = {x[62:0], x[63]};
        rot2 = {x[61:0], x[63:62]};
        rot8 = {x[55:0], x[63:56]};
        return (rot1 & rot8) ^ rot2 ^ {rk, ~rk};
    endfunction

    // One key-schedule step: rotate the key state left by 13, fold a
    // nonlinear term of the low word into the high word and mix the round
    // index into the low word so every step differs even for symmetric keys.
    function automatic logic [KEY_W-1:0] expand_key(input logic [KEY_W-1:0]  k,
                                                    input logic [RIDX_W-1:0] idx);
        logic [KEY_W-1:0] r;
        logic [31:0]      lo;
        logic [31:0]      lo_rot5;
        r       = {k[50:0], k[63:51]};
        lo      = r[31:0];
        lo_rot5 = {lo[26:0], lo[31:27]};
        return {r[63:32] ^ (lo & lo_rot5), lo ^ {26'd0, idx}};
    endfunction

endpackage

// File: rtl/decryption_seq_rkey_store.sv
// expandrey / decrypt_rkey_store
// expandrey: combinational key-schedule step shared with the encryption core.
//   key_in     : current key state K_k
//   round_idx  : round index k (6 bits)
//   key_out    : K_{k+1}
//
// decrypt_rkey_store: round-key buffer for the decryption core.
//   clock, reset : clock, asynchronous active-high reset
//   key          : external key, latched on load
//   load         : accepted start; restarts the write and read counters
//   gen_step     : write one round key and advance the key schedule
//   rd_step      : advance the read pointer toward round key 1
//   rd_key       : round key at the read pointer
//   gen_last     : the write pointer is at the last round key
//   rd_last      : the read pointer is at round key 1
//   cache_hit    : key equals the key whose schedule is already buffered
//
// Build option DECRYPT_KEY_CACHE_EN: keeps the last fully generated key and a
// valid flag so a repeated key can skip schedule generation. Without it,
// cache_hit is tied low and no cache registers exist.

module expandrey
    import decryption_seq_pkg::*;
(
    input  logic [KEY_W-1:0]  key_in,
    input  logic [RIDX_W-1:0] round_idx,
    output logic [KEY_W-1:0]  key_out
);

    assign key_out = expand_key(key_in, round_idx);

endmodule

module decrypt_rkey_store
    import decryption_seq_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [KEY_W-1:0]  key,
    input  logic              load,
    input  logic              gen_step,
    input  logic              rd_step,
    output logic [RK_W-1:0]   rd_key,
    output logic              gen_last,
    output logic              rd_last,
    output logic              cache_hit
);

    logic [KEY_W-1:0]  key_state;
    logic [KEY_W-1:0]  key_next;
    logic [RIDX_W-1:0] wr_idx;
    logic [RIDX_W-1:0] rd_idx;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [RK_W-1:0]   rk_buf [ROUNDS];

    expandrey u_expandrey (
        .key_in    (key_state),
        .round_idx (wr_idx),
        .key_out   (key_next)
    );

    // Round keys are numbered 1..ROUNDS; physical slot is index-1.
    assign wr_addr  = ADDR_W'(wr_idx - RIDX_W'(1));
    assign rd_addr  = ADDR_W'(rd_idx - RIDX_W'(1));
    assign rd_key   = rk_buf[rd_addr];
    assign gen_last = (wr_idx == RIDX_W'(ROUNDS));
    assign rd_last  = (rd_idx == RIDX_W'(1));

    // The counters saturate at their terminal values so they never step
    // past ROUNDS or below 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_state <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
        end else if (load) begin
            key_state <= key;
            wr_idx    <= RIDX_W'(1);
            rd_idx    <= RIDX_W'(ROUNDS);
        end else begin
            if (gen_step) begin
                key_state <= key_next;
                if (!gen_last) begin
                    wr_idx <= wr_idx + RIDX_W'(1);
                end
            end
            if (rd_step && !rd_last) begin
                rd_idx <= rd_idx - RIDX_W'(1);
            end
        end
    end

    // Slot k holds the upper word of K_k; K_1 is the raw key.
    always_ff @(posedge clock) begin
        if (gen_step) begin
            rk_buf[wr_addr] <= key_state[KEY_W-1:KEY_W-RK_W];
        end
    end

`ifdef DECRYPT_KEY_CACHE_EN
    logic [KEY_W-1:0] acc_key;
    logic [KEY_W-1:0] last_key;
    logic             cache_valid;

    // The buffer only describes last_key once a full generation pass has
    // finished; a miss invalidates it because generation starts overwriting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_key     <= '0;
            last_key    <= '0;
            cache_valid <= 1'b0;
        end else begin
            if (load) begin
                acc_key <= key;
                if (!cache_hit) begin
                    cache_valid <= 1'b0;
                end
            end
            if (gen_step && gen_last) begin
                last_key    <= acc_key;
                cache_valid <= 1'b1;
            end
        end
    end

    assign cache_hit = cache_valid && (key == last_key);
`else
    assign cache_hit = 1'b0;
`endif

endmodule

// File: rtl/decryption_seq.sv
// fesitel_inv / decryption_seq
// fesitel_inv: one combinational inverse Feistel round.
//   blk_in {A,B} -> blk_out {B ^ F(A, round_key), A}, undoing the forward
//   round {L,R} -> {R, L ^ F(R, round_key)}.
//
// decryption_seq: sequential 32-round decryption of a 128-bit block under a
// 64-bit key.
//   clock, reset  : clock, asynchronous active-high reset
//   Cipher, Key   : inputs, latched when a start is accepted in IDLE
//   decrypt_start : start request, only honoured in IDLE
//   decrypt_busy  : high while the round-key schedule or rounds are running
//   decrypt_end   : one-cycle completion pulse, Plain valid in that cycle
//   Plain         : recovered plaintext, held until the next completion
//
// Build option DECRYPT_KEY_CACHE_EN: a repeated key skips KEYGEN (33-cycle
// latency instead of 65).

module fesitel_inv
    import decryption_seq_pkg::*;
(
    input  logic [BLK_W-1:0] blk_in,
    input  logic [RK_W-1:0]  round_key,
    output logic [BLK_W-1:0] blk_out
);

    logic [BLK_W/2-1:0] hi;
    logic [BLK_W/2-1:0] lo;

    assign hi      = blk_in[BLK_W-1:BLK_W/2];
    assign lo      = blk_in[BLK_W/2-1:0];
    assign blk_out = {lo ^ round_f(hi, round_key), hi};

endmodule

module decryption_seq
    import decryption_seq_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [BLK_W-1:0] Cipher,
    input  logic [KEY_W-1:0] Key,
    input  logic             decrypt_start,
    output logic             decrypt_busy,
    output logic             decrypt_end,
    output logic [BLK_W-1:0] Plain
);

    dec_state_t       state;
    dec_state_t       state_next;
    logic [BLK_W-1:0] s_reg;
    logic [BLK_W-1:0] s_round;
    logic             accept;
    logic             gen_step;
    logic             rd_step;
    logic             gen_last;
    logic             rd_last;
    logic             cache_hit;
    logic [RK_W-1:0]  rd_key;

    decrypt_rkey_store u_rkey_store (
        .clock     (clock),
        .reset     (reset),
        .key       (Key),
        .load      (accept),
        .gen_step  (gen_step),
        .rd_step   (rd_step),
        .rd_key    (rd_key),
        .gen_last  (gen_last),
        .rd_last   (rd_last),
        .cache_hit (cache_hit)
    );

    fesitel_inv u_round (
        .blk_in    (s_reg),
        .round_key (rd_key),
        .blk_out   (s_round)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        gen_step   = 1'b0;
        rd_step    = 1'b0;
        case (state)
            IDLE: begin
                if (decrypt_start) begin
                    accept     = 1'b1;
                    state_next = cache_hit ? RUN : KEYGEN;
                end
            end
            KEYGEN: begin
                gen_step = 1'b1;
                if (gen_last) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                rd_step = 1'b1;
                if (rd_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the state being left, so busy
    // falls on the same edge that raises decrypt_end. The block is un-swapped
    // on entry so the inverse rounds start from the encryptor's final state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_reg        <= '0;
            Plain        <= '0;
            decrypt_busy <= 1'b0;
            decrypt_end  <= 1'b0;
        end else begin
            decrypt_busy <= (state == KEYGEN) || (state == RUN);
            decrypt_end  <= (state == DONE);
            if (accept) begin
                s_reg <= word_swap(Cipher);
            end else if (rd_step) begin
                s_reg <= s_round;
            end
            if (state == DONE) begin
                Plain <= s_reg;
            end
        end
    end

endmodule

// File: tb/tb_decryption_seq.sv
// tb_decryption_seq
// Directed bench for decryption_seq. A forward-encryption model produces the
// ciphertext for each vector; the DUT must return the original plaintext with
// the expected latency, busy duration and a single-cycle end pulse.
// Honours DECRYPT_KEY_CACHE_EN for the expected latency of repeated keys.

module tb_decryption_seq;

`ifdef DECRYPT_KEY_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic [127:0] Cipher;
    logic [63:0]  Key;
    logic         decrypt_start;
    logic         decrypt_busy;
    logic         decrypt_end;
    logic [127:0] Plain;

    int pass_cnt  = 0;
    int total_cnt = 0;

    bit          model_cache_valid = 1'b0;
    logic [63:0] model_cache_key   = '0;

    always #5 clock = ~clock;

    decryption_seq dut (
        .clock         (clock),
        .reset         (reset),
        .Cipher        (Cipher),
        .Key           (Key),
        .decrypt_start (decrypt_start),
        .decrypt_busy  (decrypt_busy),
        .decrypt_end   (decrypt_end),
        .Plain         (Plain)
    );

    function automatic logic [63:0] rotl64(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic [63:0] model_f(input logic [63:0] x, input logic [31:0] rk);
        return (rotl64(x, 1) & rotl64(x, 8)) ^ rotl64(x, 2) ^ {rk, ~rk};
    endfunction

    function automatic logic [63:0] model_expand(input logic [63:0] k, input logic [5:0] idx);
        logic [63:0] r;
        logic [31:0] lo;
        logic [31:0] lo5;
        r   = rotl64(k, 13);
        lo  = r[31:0];
        lo5 = (lo << 5) | (lo >> 27);
        return {r[63:32] ^ (lo & lo5), lo ^ {26'd0, idx}};
    endfunction

    // Forward 32-round encryption, output halves swapped.
    function automatic logic [127:0] model_encrypt(input logic [127:0] p, input logic [63:0] key);
        logic [31:0]  rk [1:32];
        logic [63:0]  ks;
        logic [127:0] s;
        ks    = key;
        rk[1] = key[63:32];
        for (int i = 1; i < 32; i++) begin
            ks        = model_expand(ks, 6'(i));
            rk[i + 1] = ks[63:32];
        end
        s = p;
        for (int i = 1; i <= 32; i++) begin
            s = {s[63:0], s[127:64] ^ model_f(s[63:0], rk[i])};
        end
        return {s[63:0], s[127:64]};
    endfunction

    function automatic int expected_latency(input logic [63:0] key);
        return (CACHE_EN && model_cache_valid && (key == model_cache_key)) ? 33 : 65;
    endfunction

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        decrypt_start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        model_cache_valid = 1'b0;
    endtask

    // Start one decryption and follow it to completion (bounded at 200 edges).
    // lat is -1 when no end pulse appeared.
    task automatic run_op(input logic [127:0] c, input logic [63:0] k, input bit scramble,
                          output logic [127:0] plain_out, output int lat,
                          output int busy_cnt, output int end_width);
        @(negedge clock);
        Cipher        = c;
        Key           = k;
        decrypt_start = 1'b1;
        @(posedge clock);
        #1;
        decrypt_start = 1'b0;
        lat       = -1;
        busy_cnt  = 0;
        end_width = 0;
        plain_out = '0;
        if (decrypt_busy) busy_cnt++;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clock);
            #1;
            if (scramble && n == 10) begin
                Cipher = ~c;
                Key    = ~k ^ 64'h5;
            end
            if (decrypt_busy) busy_cnt++;
            if (decrypt_end) begin
                lat       = n;
                plain_out = Plain;
                break;
            end
        end
        if (lat > 0) begin
            end_width = 1;
            for (int n = 0; n < 4; n++) begin
                @(posedge clock);
                #1;
                if (!decrypt_end) break;
                end_width++;
            end
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        decrypt_start = 1'b0;
        Cipher        = '0;
        Key           = '0;
        repeat (3) @(posedge clock);
        #1;
        total_cnt++;
        if (decrypt_busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", decrypt_busy);
        else pass_cnt++;
        total_cnt++;
        if (decrypt_end !== 1'b0) $display("[TB] FAIL reset_end: got %b expected 0", decrypt_end);
        else pass_cnt++;
        total_cnt++;
        if (Plain !== 128'd0) $display("[TB] FAIL reset_plain: got %h expected 0", Plain);
        else pass_cnt++;
        @(negedge clock);
        reset = 1'b0;
        model_cache_valid = 1'b0;
    endtask

    task automatic test_round_trip(input string name, input logic [127:0] p,
                                   input logic [63:0] k, input bit scramble);
        logic [127:0] c;
        logic [127:0] got;
        int           lat;
        int           busy_cnt;
        int           end_width;
        int           exp_lat;
        c       = model_encrypt(p, k);
        exp_lat = expected_latency(k);
        run_op(c, k, scramble, got, lat, busy_cnt, end_width);
        total_cnt++;
        if (got !== p) $display("[TB] FAIL %s_plain: got %h expected %h", name, got, p);
        else pass_cnt++;
        total_cnt++;
        if (lat !== exp_lat) $display("[TB] FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
        else pass_cnt++;
        total_cnt++;
        if (busy_cnt !== exp_lat - 1)
            $display("[TB] FAIL %s_busy_cycles: got %0d expected %0d", name, busy_cnt, exp_lat - 1);
        else pass_cnt++;
        total_cnt++;
        if (end_width !== 1) $display("[TB] FAIL %s_end_width: got %0d expected 1", name, end_width);
        else pass_cnt++;
        if (exp_lat == 65) begin
            model_cache_valid = 1'b1;
            model_cache_key   = k;
        end
    endtask

    task automatic test_reset_mid_op();
        logic [127:0] p;
        logic [63:0]  k;
        p = 128'h00112233445566778899AABBCCDDEEFF;
        k = 64'hA5A5F00D1234C3C3;
        @(negedge clock);
        Cipher        = model_encrypt(p, k);
        Key           = k;
        decrypt_start = 1'b1;
        @(posedge clock);
        #1;
        decrypt_start = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        total_cnt++;
        if (decrypt_busy !== 1'b1) $display("[TB] FAIL midop_busy_before_reset: got %b expected 1", decrypt_busy);
        else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (decrypt_busy !== 1'b0) $display("[TB] FAIL midop_async_busy: got %b expected 0", decrypt_busy);
        else pass_cnt++;
        total_cnt++;
        if (decrypt_end !== 1'b0) $display("[TB] FAIL midop_async_end: got %b expected 0", decrypt_end);
        else pass_cnt++;
        total_cnt++;
        if (Plain !== 128'd0) $display("[TB] FAIL midop_async_plain: got %h expected 0", Plain);
        else pass_cnt++;
        @(negedge clock);
        reset = 1'b0;
        model_cache_valid = 1'b0;
        test_round_trip("after_reset", p, k, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [127:0] p;
        logic [63:0]  k;
        int           exp_ends[$];
        int           got_ends[$];
        int           t;
        int           lat;
        int           plain_bad;
        p = 128'hDEADBEEF0BADF00DCAFEBABE13579BDF;
        k = 64'h0F1E2D3C4B5A6978;
        pulse_reset();
        t = 0;
        lat = 65;
        while (t + lat <= 199) begin
            exp_ends.push_back(t + lat);
            t   = t + lat + 1;
            lat = CACHE_EN ? 33 : 65;
        end
        plain_bad = 0;
        @(negedge clock);
        Cipher        = model_encrypt(p, k);
        Key           = k;
        decrypt_start = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(posedge clock);
            #1;
            if (decrypt_end) begin
                got_ends.push_back(n);
                if (Plain !== p) plain_bad++;
            end
        end
        decrypt_start = 1'b0;
        total_cnt++;
        if (got_ends.size() !== exp_ends.size())
            $display("[TB] FAIL b2b_end_count: got %0d expected %0d", got_ends.size(), exp_ends.size());
        else pass_cnt++;
        for (int i = 0; i < exp_ends.size(); i++) begin
            total_cnt++;
            if (i >= got_ends.size())
                $display("[TB] FAIL b2b_end_%0d: got none expected cycle %0d", i, exp_ends[i]);
            else if (got_ends[i] !== exp_ends[i])
                $display("[TB] FAIL b2b_end_%0d: got cycle %0d expected cycle %0d", i, got_ends[i], exp_ends[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (plain_bad !== 0) $display("[TB] FAIL b2b_plain: got %0d wrong results expected 0", plain_bad);
        else pass_cnt++;
        pulse_reset();
    endtask

    task automatic test_key_cache();
        logic [63:0] ka;
        logic [63:0] kb;
        ka = 64'h13579BDF2468ACE0;
        kb = 64'hFEDCBA9876543210;
        test_round_trip("cache_first", 128'h0000000100000002000000030000000F, ka, 1'b0);
        test_round_trip("cache_repeat", 128'h89ABCDEF01234567F0E1D2C3B4A59687, ka, 1'b0);
        test_round_trip("cache_newkey", 128'h7777666655554444333322221111AAAA, kb, 1'b0);
    endtask

    initial begin
        $display("[TB] starting decryption_seq bench (key cache %0d)", CACHE_EN);
        test_reset();
        test_round_trip("spec_vector", 128'h0123456789ABCDEFFEDCBA9876543210, 64'h0123456789ABCDEF, 1'b0);
        test_round_trip("all_zero", 128'h0, 64'h0, 1'b0);
        test_round_trip("all_ones", {128{1'b1}}, {64{1'b1}}, 1'b0);
        test_reset_mid_op();
        test_round_trip("input_change", 128'hC001D00DFACEFEED5EED0123BEEF4567, 64'h55AA33CC0FF01E2D, 1'b1);
        test_back_to_back();
        test_key_cache();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
